// File: rtl/pcileech_pcie_tx_arbiter_pkg.sv
// Shared types and constants for the PCIe TX arbiter.
// Used by pcileech_pcie_tx_arbiter and pcileech_rr_pick.
package pcileech_pcie_tx_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        CFG  = 2'd2
    } tx_arb_state_t;

    localparam int TXBUF_MIN_DEFAULT = 2;

    // Index width that stays at least one bit wide for degenerate sizes.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pcileech_rr_pick.sv
// Combinational rotate-priority encoder: returns the first asserted request
// at or after i_ptr, wrapping modulo N, plus a found flag.
module pcileech_rr_pick
    import pcileech_pcie_tx_arbiter_pkg::*;
#(
    parameter int N = 3,
    parameter int W = idx_width(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_ptr,
    output logic [W-1:0] o_idx,
    output logic         o_found
);

    logic [N-1:0] w_rot;
    logic [W:0]   w_sum;

    // Rotate so bit 0 is the pointer position; the lowest set bit wins.
    always_comb begin
        w_rot   = N'({i_req, i_req} >> i_ptr);
        w_sum   = '0;
        o_idx   = '0;
        o_found = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                o_found = 1'b1;
                w_sum   = {1'b0, i_ptr} + (W + 1)'(k);
                if (w_sum >= (W + 1)'(N)) begin
                    o_idx = W'(w_sum - (W + 1)'(N));
                end else begin
                    o_idx = W'(w_sum);
                end
            end
        end
    end

endmodule

// File: rtl/pcileech_pcie_tx_arbiter.sv
// Packet-granular round-robin arbiter for the PCIe core's 64-bit TX stream,
// also sequencing the core's internal config-TLP grant.
// Optional: PCILEECH_TXARB_PRIO0_EN gives source 0 strict priority.
module pcileech_pcie_tx_arbiter
    import pcileech_pcie_tx_arbiter_pkg::*;
#(
    parameter int NSRC      = 3,
    parameter int TXBUF_MIN = TXBUF_MIN_DEFAULT
) (
    input  logic                     i_clk_pcie,
    input  logic                     i_rst,
    input  logic [NSRC*64-1:0]       i_src_data,
    input  logic [NSRC*8-1:0]        i_src_keep,
    input  logic [NSRC-1:0]          i_src_last,
    input  logic [NSRC-1:0]          i_src_valid,
    output logic [NSRC-1:0]          o_src_ready,
    output logic [63:0]              o_tx_data,
    output logic [7:0]               o_tx_keep,
    output logic                     o_tx_last,
    output logic                     o_tx_valid,
    input  logic                     i_tx_ready,
    input  logic [5:0]               i_tx_buf_av,
    input  logic                     i_tx_cfg_req,
    output logic                     o_tx_cfg_gnt,
    output logic [$clog2(NSRC)-1:0]  o_grant_id,
    output logic                     o_grant_active
);

    localparam int         GW      = $clog2(NSRC);
    localparam logic [5:0] BUF_MIN = 6'(TXBUF_MIN);

    tx_arb_state_t r_state, w_state_nxt;
    logic [GW-1:0] r_rr_ptr, w_rr_ptr_nxt;
    logic [GW-1:0] r_grant_id, w_grant_id_nxt;
    logic [GW-1:0] w_pick_idx, w_win_idx, w_rr_after, w_rr_end;
    logic          w_pick_found, w_win_found;
    logic [NSRC-1:0] w_pick_req;
    logic [63:0]   w_sel_data;
    logic [7:0]    w_sel_keep;
    logic          w_sel_last, w_sel_valid, w_pkt_end;

`ifdef PCILEECH_TXARB_PRIO0_EN
    // Source 0 bypasses the rotation; the others share it and the pointer skips 0.
    assign w_pick_req  = {i_src_valid[NSRC-1:1], 1'b0};
    assign w_win_idx   = i_src_valid[0] ? '0 : w_pick_idx;
    assign w_win_found = |i_src_valid;
    assign w_rr_end    = (r_grant_id == '0) ? r_rr_ptr :
                         (w_rr_after == '0) ? GW'(1) : w_rr_after;
`else
    assign w_pick_req  = i_src_valid;
    assign w_win_idx   = w_pick_idx;
    assign w_win_found = w_pick_found;
    assign w_rr_end    = w_rr_after;
`endif

    assign w_rr_after = (r_grant_id == GW'(NSRC - 1)) ? '0 : r_grant_id + GW'(1);

    pcileech_rr_pick #(
        .N (NSRC),
        .W (GW)
    ) u_rr_pick (
        .i_req   (w_pick_req),
        .i_ptr   (r_rr_ptr),
        .o_idx   (w_pick_idx),
        .o_found (w_pick_found)
    );

    always_comb begin
        w_sel_data  = '0;
        w_sel_keep  = '0;
        w_sel_last  = 1'b0;
        w_sel_valid = 1'b0;
        for (int i = 0; i < NSRC; i++) begin
            if (r_grant_id == GW'(i)) begin
                w_sel_data  = i_src_data[i*64 +: 64];
                w_sel_keep  = i_src_keep[i*8 +: 8];
                w_sel_last  = i_src_last[i];
                w_sel_valid = i_src_valid[i];
            end
        end
    end

    assign w_pkt_end = (r_state == BUSY) && w_sel_valid && i_tx_ready && w_sel_last;

    always_ff @(posedge i_clk_pcie) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_rr_ptr   <= '0;
            r_grant_id <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_rr_ptr   <= w_rr_ptr_nxt;
            r_grant_id <= w_grant_id_nxt;
        end
    end

    // Config requests win over user sources only at a packet boundary.
    always_comb begin
        w_state_nxt    = r_state;
        w_rr_ptr_nxt   = r_rr_ptr;
        w_grant_id_nxt = r_grant_id;
        case (r_state)
            IDLE: begin
                if (i_tx_cfg_req) begin
                    w_state_nxt = CFG;
                end else if (w_win_found && (i_tx_buf_av >= BUF_MIN)) begin
                    w_state_nxt    = BUSY;
                    w_grant_id_nxt = w_win_idx;
                end
            end
            CFG: begin
                if (!i_tx_cfg_req) begin
                    w_state_nxt = IDLE;
                end
            end
            BUSY: begin
                if (w_pkt_end) begin
                    w_state_nxt  = IDLE;
                    w_rr_ptr_nxt = w_rr_end;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_tx_data   = '0;
        o_tx_keep   = '0;
        o_tx_last   = 1'b0;
        o_tx_valid  = 1'b0;
        o_src_ready = '0;
        if (r_state == BUSY) begin
            o_tx_data  = w_sel_data;
            o_tx_keep  = w_sel_keep;
            o_tx_last  = w_sel_last;
            o_tx_valid = w_sel_valid;
            for (int i = 0; i < NSRC; i++) begin
                if (r_grant_id == GW'(i)) begin
                    o_src_ready[i] = i_tx_ready;
                end
            end
        end
    end

    assign o_tx_cfg_gnt   = (r_state == CFG);
    assign o_grant_active = (r_state == BUSY);
    assign o_grant_id     = r_grant_id;

endmodule
